// File: rtl/rll_key_loader_if.sv
// ---------------------------------------------------------------------------
// rll_key_loader_if
//   Valid/ready stream carrying key words from key storage to the loader.
//
//   Signals
//     kw_valid  source -> loader  key word valid
//     kw_data   source -> loader  key word, WORD_W bits (word 0 = key LSBs)
//     kw_ready  loader -> source  loader accepts the word this cycle
//
//   Modports
//     master : key storage side (drives valid/data, observes ready)
//     slave  : loader side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface rll_key_loader_if #(
    parameter int WORD_W = 8
);
    logic              kw_valid;
    logic [WORD_W-1:0] kw_data;
    logic              kw_ready;

    modport master (
        output kw_valid,
        output kw_data,
        input  kw_ready
    );

    modport slave (
        input  kw_valid,
        input  kw_data,
        output kw_ready
    );
endinterface

// File: rtl/rll_key_loader.sv
// ---------------------------------------------------------------------------
// rll_key_loader
//   Delivers the key to an RLL-locked combinational core. The key is fetched
//   as NWORDS = KEY_W/WORD_W words over a valid/ready stream, assembled in a
//   shadow register and only then committed in a single cycle to key_out, so
//   the core never sees a partially loaded key. The core's primary outputs
//   are forced to zero until a complete key is armed. A zeroize pulse wipes
//   the key from every register and returns the loader to IDLE.
//   KEY_W must be an integer multiple of WORD_W.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     start      in   pulse: begin a key fetch (honoured in IDLE/ARMED/ERROR)
//     zeroize    in   pulse: clear key, drop armed, return to IDLE
//     kif        slave modport of rll_key_loader_if (kw_valid/kw_data/kw_ready)
//     key_out    out  key bus to the core, bit i -> keyIn_0_i
//     core_out   in   raw locked-core outputs (LSB = n101)
//     gated_out  out  core_out while armed, otherwise all zeros
//     armed      out  a complete key is committed and outputs are released
//     busy       out  fetch or commit in progress
//     err        out  sticky word-timeout flag, cleared by start/zeroize/rst
// ---------------------------------------------------------------------------
module rll_key_loader #(
    parameter int KEY_W   = 32,
    parameter int WORD_W  = 8,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200,
    parameter int OUT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zeroize,
    rll_key_loader_if.slave  kif,
    output logic [KEY_W-1:0] key_out,
    input  logic [OUT_W-1:0] core_out,
    output logic [OUT_W-1:0] gated_out,
    output logic             armed,
    output logic             busy,
    output logic             err
);

    localparam int NWORDS = KEY_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_ARMED  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Registered state and outputs
    state_t             state_r;
    logic [KEY_W-1:0]   shadow_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [KEY_W-1:0]   key_out_r;
    logic               armed_r;
    logic               err_r;
    logic               kw_ready_r;
    logic               busy_r;

    // Next-state values
    state_t             state_s;
    logic [KEY_W-1:0]   shadow_s;
    logic [CNT_W-1:0]   word_cnt_s;
    logic [TMO_W-1:0]   tmo_s;
    logic [KEY_W-1:0]   key_out_s;
    logic               armed_s;
    logic               err_s;
    logic               kw_ready_s;
    logic               busy_s;

    logic               handshake_s;

    // kw_ready_r is high exactly while in FETCH, so this is the accept strobe.
    assign handshake_s = kif.kw_valid & kw_ready_r;

    // Next-state and next-output logic for the loader sequence.
    always_comb begin
        state_s    = state_r;
        shadow_s   = shadow_r;
        word_cnt_s = word_cnt_r;
        tmo_s      = tmo_r;
        key_out_s  = key_out_r;
        armed_s    = armed_r;
        err_s      = err_r;

        if (zeroize) begin
            // Zeroize wins over start and over an accepted word in the same cycle.
            state_s    = ST_IDLE;
            shadow_s   = {KEY_W{1'b0}};
            word_cnt_s = {CNT_W{1'b0}};
            tmo_s      = {TMO_W{1'b0}};
            key_out_s  = {KEY_W{1'b0}};
            armed_s    = 1'b0;
            err_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ARMED, ST_ERROR: begin
                    if (start) begin
                        // The previous key (and armed) stay live until COMMIT.
                        state_s    = ST_FETCH;
                        shadow_s   = {KEY_W{1'b0}};
                        word_cnt_s = {CNT_W{1'b0}};
                        tmo_s      = {TMO_W{1'b0}};
                        err_s      = 1'b0;
                    end else begin
                        state_s    = state_r;
                    end
                end

                ST_FETCH: begin
                    if (handshake_s) begin
                        for (int w = 0; w < NWORDS; w++) begin
                            shadow_s[w*WORD_W +: WORD_W] =
                                (word_cnt_r == CNT_W'(w)) ? kif.kw_data
                                                          : shadow_r[w*WORD_W +: WORD_W];
                        end
                        tmo_s = {TMO_W{1'b0}};
                        if (word_cnt_r == LAST_WORD) begin
                            state_s    = ST_COMMIT;
                            word_cnt_s = {CNT_W{1'b0}};
                        end else begin
                            word_cnt_s = word_cnt_r + CNT_W'(1);
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        // Key source stalled: drop everything, including any
                        // previously armed key, and flag the error.
                        state_s    = ST_ERROR;
                        shadow_s   = {KEY_W{1'b0}};
                        word_cnt_s = {CNT_W{1'b0}};
                        tmo_s      = {TMO_W{1'b0}};
                        key_out_s  = {KEY_W{1'b0}};
                        armed_s    = 1'b0;
                        err_s      = 1'b1;
                    end else begin
                        tmo_s      = tmo_r + TMO_W'(1);
                    end
                end

                ST_COMMIT: begin
                    // Atomic hand-over; the shadow copy is wiped once used.
                    state_s    = ST_ARMED;
                    key_out_s  = shadow_r;
                    shadow_s   = {KEY_W{1'b0}};
                    armed_s    = 1'b1;
                end

                default: begin
                    // Unreachable encoding: recover to a safe, keyless IDLE.
                    state_s    = ST_IDLE;
                    shadow_s   = {KEY_W{1'b0}};
                    word_cnt_s = {CNT_W{1'b0}};
                    tmo_s      = {TMO_W{1'b0}};
                    key_out_s  = {KEY_W{1'b0}};
                    armed_s    = 1'b0;
                    err_s      = 1'b0;
                end
            endcase
        end

        // Status flags are registered from the next state so they line up with it.
        kw_ready_s = (state_s == ST_FETCH);
        busy_s     = (state_s == ST_FETCH) || (state_s == ST_COMMIT);
    end

    // State and output registers; rst clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shadow_r   <= {KEY_W{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
            tmo_r      <= {TMO_W{1'b0}};
            key_out_r  <= {KEY_W{1'b0}};
            armed_r    <= 1'b0;
            err_r      <= 1'b0;
            kw_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shadow_r   <= shadow_s;
            word_cnt_r <= word_cnt_s;
            tmo_r      <= tmo_s;
            key_out_r  <= key_out_s;
            armed_r    <= armed_s;
            err_r      <= err_s;
            kw_ready_r <= kw_ready_s;
            busy_r     <= busy_s;
        end
    end

    assign kif.kw_ready = kw_ready_r;
    assign key_out      = key_out_r;
    assign armed        = armed_r;
    assign busy         = busy_r;
    assign err          = err_r;

    // Output masking follows armed combinationally so it releases with the key.
    assign gated_out    = core_out & {OUT_W{armed_r}};

endmodule

// File: tb/tb_rll_key_loader.sv
// ---------------------------------------------------------------------------
// tb_rll_key_loader
//   Directed bench for rll_key_loader. A transaction-level model (list of
//   collected words, idle-cycle count, pending commit) predicts every output
//   each cycle; directed checks pin the model and the cycle-exact latencies.
// ---------------------------------------------------------------------------
module tb_rll_key_loader;

    localparam int KEY_W   = 32;
    localparam int WORD_W  = 8;
    localparam int NWORDS  = 4;
    localparam int TMO_MAX = 200;
    localparam int OUT_W   = 32;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              start    = 1'b0;
    logic              zeroize  = 1'b0;
    logic [OUT_W-1:0]  core_out = 32'hFFFF_FFFF;
    logic [KEY_W-1:0]  key_out;
    logic [OUT_W-1:0]  gated_out;
    logic              armed;
    logic              busy;
    logic              err;

    rll_key_loader_if #(.WORD_W(WORD_W)) kif ();

    rll_key_loader #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W),
        .TMO_W  (8),
        .TMO_MAX(TMO_MAX),
        .OUT_W  (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .zeroize  (zeroize),
        .kif      (kif),
        .key_out  (key_out),
        .core_out (core_out),
        .gated_out(gated_out),
        .armed    (armed),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_fetching = 1'b0;
    bit               m_commit   = 1'b0;
    bit               m_armed    = 1'b0;
    bit               m_err      = 1'b0;
    logic [KEY_W-1:0] m_key      = 32'h0;
    logic [7:0]       m_words[$];
    int               m_idle     = 0;

    initial begin
        kif.kw_valid = 1'b0;
        kif.kw_data  = 8'h00;
        forever begin
            @(posedge clk);
            if (rst || zeroize) begin
                m_fetching = 1'b0;
                m_commit   = 1'b0;
                m_armed    = 1'b0;
                m_err      = 1'b0;
                m_key      = 32'h0;
                m_idle     = 0;
                m_words.delete();
            end else if (m_fetching) begin
                if (kif.kw_valid) begin
                    m_words.push_back(kif.kw_data);
                    m_idle = 0;
                    if (m_words.size() == NWORDS) begin
                        m_fetching = 1'b0;
                        m_commit   = 1'b1;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TMO_MAX) begin
                        m_fetching = 1'b0;
                        m_err      = 1'b1;
                        m_armed    = 1'b0;
                        m_key      = 32'h0;
                        m_words.delete();
                    end
                end
            end else if (m_commit) begin
                m_key = 32'h0;
                foreach (m_words[i]) m_key[i*8 +: 8] = m_words[i];
                m_armed  = 1'b1;
                m_commit = 1'b0;
                m_words.delete();
            end else if (start) begin
                m_fetching = 1'b1;
                m_idle     = 0;
                m_err      = 1'b0;
                m_words.delete();
            end
            #1;
            check("cyc_key_out",   key_out,      m_key);
            check("cyc_armed",     armed,        {31'h0, m_armed});
            check("cyc_busy",      busy,         {31'h0, m_fetching | m_commit});
            check("cyc_err",       err,          {31'h0, m_err});
            check("cyc_kw_ready",  kif.kw_ready, {31'h0, m_fetching});
            check("cyc_gated_out", gated_out,    core_out & {32{m_armed}});
        end
    end

    // ---------------- stimulus helpers (enter/leave just after a negedge) ----------------
    // Full load; checks that the old key/armed hold until the exact commit cycle.
    task automatic load(input logic [31:0] key, input int gap,
                        input logic [31:0] prev_key, input logic prev_armed);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_err_clear", err,  32'h0);
        check("load_busy",      busy, 32'h1);
        for (int i = 0; i < NWORDS; i++) begin
            kif.kw_valid = 1'b1;
            kif.kw_data  = key[i*8 +: 8];
            @(negedge clk);
            kif.kw_valid = 1'b0;
            check("load_key_held",   key_out, prev_key);
            check("load_armed_held", armed,   {31'h0, prev_armed});
            if (i != NWORDS - 1) repeat (gap) begin
                @(negedge clk);
                check("load_key_held_gap", key_out, prev_key);
            end
        end
        // COMMIT cycle: old key still visible, new key after this edge.
        check("load_commit_key_old", key_out, prev_key);
        check("load_commit_busy",    busy,    32'h1);
        @(negedge clk);
        check("load_key_new", key_out, key);
        check("load_armed",   armed,   32'h1);
        check("load_busy_off", busy,   32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset with all core outputs high
        @(negedge clk);
        @(negedge clk);
        check("rst_gated_out", gated_out,    32'h0);
        check("rst_key_out",   key_out,      32'h0);
        check("rst_armed",     armed,        32'h0);
        check("rst_kw_ready",  kif.kw_ready, 32'h0);
        check("rst_busy",      busy,         32'h0);
        check("rst_err",       err,          32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 2: back-to-back load, armed 6 cycles after start
        load(32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        check("model_key_deadbeef", m_key, 32'hDEAD_BEEF);
        core_out = 32'h0F0F_1234;
        @(negedge clk);
        check("t2_gated_pass", gated_out, 32'h0F0F_1234);

        // 3: three idle cycles between words, armed 15 cycles after start
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check("t3_pre_zero", key_out, 32'h0);
        load(32'hDEAD_BEEF, 3, 32'h0, 1'b0);

        // 4: timeout after two words, from ARMED
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kif.kw_valid = 1'b1; kif.kw_data = 8'hEF;
        @(negedge clk);
        kif.kw_data = 8'hBE;
        @(negedge clk);
        kif.kw_valid = 1'b0;
        repeat (TMO_MAX - 1) @(negedge clk);
        check("t4_no_err_yet",   err,     32'h0);
        check("t4_still_armed",  armed,   32'h1);
        check("t4_key_kept",     key_out, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t4_err",          err,       32'h1);
        check("t4_armed_drop",   armed,     32'h0);
        check("t4_key_cleared",  key_out,   32'h0);
        check("t4_gated_zero",   gated_out, 32'h0);
        repeat (3) @(negedge clk);
        check("t4_err_sticky",   err,       32'h1);
        load(32'hDEAD_BEEF, 0, 32'h0, 1'b0);

        // 5: reload from ARMED, armed never drops
        core_out = 32'hA5C3_0F96;
        load(32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b1);
        check("model_key_12345678", m_key, 32'h1234_5678);
        check("t5_gated_pass", gated_out, 32'hA5C3_0F96);

        // 6a: zeroize coincident with the third word
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kif.kw_valid = 1'b1; kif.kw_data = 8'h11;
        @(negedge clk);
        kif.kw_data = 8'h22;
        @(negedge clk);
        kif.kw_data = 8'h33;
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        kif.kw_valid = 1'b0;
        check("t6_zkey",    key_out,      32'h0);
        check("t6_zarmed",  armed,        32'h0);
        check("t6_zbusy",   busy,         32'h0);
        check("t6_zready",  kif.kw_ready, 32'h0);
        check("t6_zgated",  gated_out,    32'h0);
        repeat (2) @(negedge clk);
        load(32'hCAFE_F00D, 0, 32'h0, 1'b0);

        // 6b: zeroize together with start
        start = 1'b1; zeroize = 1'b1;
        @(negedge clk);
        start = 1'b0; zeroize = 1'b0;
        check("t6_zs_armed", armed,   32'h0);
        check("t6_zs_busy",  busy,    32'h0);
        check("t6_zs_key",   key_out, 32'h0);
        @(negedge clk);
        check("t6_zs_idle",  busy,    32'h0);

        // 6c: asynchronous reset mid-fetch while a key is armed
        load(32'h1234_5678, 0, 32'h0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kif.kw_valid = 1'b1; kif.kw_data = 8'h78;
        @(negedge clk);
        kif.kw_data = 8'h56;
        @(negedge clk);
        kif.kw_data = 8'h34;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_key_async",   key_out,   32'h0);
        check("t6_rst_armed_async", armed,     32'h0);
        check("t6_rst_busy_async",  busy,      32'h0);
        check("t6_rst_gated_async", gated_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_post_rst_key",   key_out, 32'h0);
            check("t6_post_rst_armed", armed,   32'h0);
        end
        kif.kw_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
